id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 31 +++
 rtl/id_hazard_unit.sv | 36 +++
 rtl/id_ex_stage.sv | 130 +++++++++++++
 tb/tb_id_ex_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: control-word layout, bubble constant and
// the kinds of load the ID/EX register can perform on a clock edge.
package id_ex_stage_pkg;

    localparam int CTRL_W = 9;

    // Bit positions inside the packed control word, MSB first.
    localparam int CTRL_REG_WRITE  = 8;
    localparam int CTRL_MEM_READ   = 7;
    localparam int CTRL_MEM_WRITE  = 6;
    localparam int CTRL_MEM_TO_REG = 5;
    localparam int CTRL_BRANCH     = 4;
    localparam int CTRL_ALU_SRC    = 3;
    localparam int CTRL_ALU_OP_MSB = 2;
    localparam int CTRL_ALU_OP_LSB = 1;
    localparam int CTRL_FUNCT_ALT  = 0;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        LOAD_RESET,
        LOAD_FLUSH,
        LOAD_BUBBLE,
        LOAD_NORMAL
    } load_kind_e;

    function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEM_READ];
    endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// Load-use hazard detection and writeback bypass selection for the
// operands entering the EX stage. Purely combinational.
module id_hazard_unit
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [XLEN-1:0]   id_rdata1,
    input  logic [XLEN-1:0]   id_rdata2,
    input  logic              ex_valid,
    input  logic [4:0]        ex_rd,
    input  logic [CTRL_W-1:0] ex_ctrl,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              hazard,
    output logic [XLEN-1:0]   op1,
    output logic [XLEN-1:0]   op2
);

    logic ex_loads_rd;
    logic wb_writes_rd;

    // x0 is hard-wired to zero, so it never forms a hazard or a bypass.
    assign ex_loads_rd  = ex_valid & ctrl_mem_read(ex_ctrl) & (ex_rd != 5'd0);
    assign wb_writes_rd = wb_reg_write & (wb_rd != 5'd0);

    assign hazard = id_valid & ex_loads_rd & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    assign op1 = (wb_writes_rd && (wb_rd == id_rs1)) ? wb_data : id_rdata1;
    assign op2 = (wb_writes_rd && (wb_rd == id_rs2)) ? wb_data : id_rdata2;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion,
// flush handling and saturating stall/flush event counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int CNTW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_rdata1,
    input  logic [XLEN-1:0]   id_rdata2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNTW-1:0]   stall_cnt,
    output logic [CNTW-1:0]   flush_cnt
);

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic            hazard;
    logic [XLEN-1:0] fwd_op1;
    logic [XLEN-1:0] fwd_op2;
    load_kind_e      load_kind;
    logic            flush_counts;

    id_hazard_unit #(.XLEN(XLEN)) u_hazard (
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rdata1    (id_rdata1),
        .id_rdata2    (id_rdata2),
        .ex_valid     (ex_valid),
        .ex_rd        (ex_rd),
        .ex_ctrl      (ex_ctrl),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .hazard       (hazard),
        .op1          (fwd_op1),
        .op2          (fwd_op2)
    );

    assign stall_out    = hazard & ~flush & reset;
    assign flush_counts = flush & id_valid & reset;

    always_comb begin
        load_kind = LOAD_NORMAL;
        if (!reset) begin
            load_kind = LOAD_RESET;
        end else if (flush) begin
            load_kind = LOAD_FLUSH;
        end else if (hazard) begin
            load_kind = LOAD_BUBBLE;
        end
    end

    // Data fields are captured on bubbles too; only valid/ctrl matter there.
    always_ff @(posedge clk) begin
        case (load_kind)
            LOAD_RESET: begin
                ex_valid <= 1'b0;
                ex_ctrl  <= CTRL_BUBBLE;
                ex_pc    <= '0;
                ex_rs1   <= '0;
                ex_rs2   <= '0;
                ex_rd    <= '0;
                ex_op1   <= '0;
                ex_op2   <= '0;
                ex_imm   <= '0;
            end
            LOAD_FLUSH, LOAD_BUBBLE: begin
                ex_valid <= 1'b0;
                ex_ctrl  <= CTRL_BUBBLE;
                ex_pc    <= id_pc;
                ex_rs1   <= id_rs1;
                ex_rs2   <= id_rs2;
                ex_rd    <= id_rd;
                ex_op1   <= fwd_op1;
                ex_op2   <= fwd_op2;
                ex_imm   <= id_imm;
            end
            default: begin
                ex_valid <= id_valid;
                ex_ctrl  <= id_valid ? id_ctrl : CTRL_BUBBLE;
                ex_pc    <= id_pc;
                ex_rs1   <= id_rs1;
                ex_rs2   <= id_rs2;
                ex_rd    <= id_rd;
                ex_op1   <= fwd_op1;
                ex_op2   <= fwd_op2;
                ex_imm   <= id_imm;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_out && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_counts && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; a narrow-counter second instance shares
// the stimulus so counter saturation is reachable in a short run.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int XLEN    = 64;
    localparam int CNTW    = 32;
    localparam int SMALL_W = 4;
    localparam int SMALL_MAX = (1 << SMALL_W) - 1;

    localparam logic [8:0] CTRL_ALU = 9'b100000100;
    localparam logic [8:0] CTRL_LD  = 9'b110101000;
    localparam logic [8:0] CTRL_SD  = 9'b001001000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, id_valid, wb_reg_write, flush;
    logic [XLEN-1:0]   id_pc, id_rdata1, id_rdata2, id_imm, wb_data;
    logic [4:0]        id_rs1, id_rs2, id_rd, wb_rd;
    logic [CTRL_W-1:0] id_ctrl;

    logic              stall_out, ex_valid;
    logic [XLEN-1:0]   ex_pc, ex_op1, ex_op2, ex_imm;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNTW-1:0]   stall_cnt, flush_cnt;

    logic              s_stall_out, s_ex_valid;
    logic [XLEN-1:0]   s_ex_pc, s_ex_op1, s_ex_op2, s_ex_imm;
    logic [4:0]        s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic [CTRL_W-1:0] s_ex_ctrl;
    logic [SMALL_W-1:0] s_stall_cnt, s_flush_cnt;

    id_ex_stage #(.XLEN(XLEN), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .flush(flush), .stall_out(stall_out),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
        .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.XLEN(XLEN), .CNTW(SMALL_W)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .flush(flush), .stall_out(s_stall_out),
        .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2),
        .ex_rd(s_ex_rd), .ex_op1(s_ex_op1), .ex_op2(s_ex_op2), .ex_imm(s_ex_imm),
        .ex_ctrl(s_ex_ctrl), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        logic       valid;
        logic [8:0] ctrl;
        logic       data_known;
        logic [XLEN-1:0] pc, op1, op2, imm;
        logic [4:0] rs1, rs2, rd;
        int         n_stall, n_flush;
    } exp_t;

    exp_t sb[$];

    logic       m_valid;
    logic [4:0] m_rd;
    logic [8:0] m_ctrl;
    int n_stall, n_flush;
    int checks, failures;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [XLEN-1:0] r1,
                             input logic [XLEN-1:0] r2, input logic [8:0] ctrl);
        id_valid  = v;
        id_pc     = {$urandom, $urandom};
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        id_rdata1 = r1;
        id_rdata2 = r2;
        id_imm    = {$urandom, $urandom};
        id_ctrl   = ctrl;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [XLEN-1:0] d);
        wb_reg_write = we;
        wb_rd        = rd;
        wb_data      = d;
    endtask

    task automatic check_output();
        exp_t e;
        int small_s, small_f;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check("ex_valid", 64'(ex_valid), 64'(e.valid));
        check("ex_ctrl", 64'(ex_ctrl), 64'(e.ctrl));
        if (e.data_known) begin
            check("ex_pc", ex_pc, e.pc);
            check("ex_rs1", 64'(ex_rs1), 64'(e.rs1));
            check("ex_rs2", 64'(ex_rs2), 64'(e.rs2));
            check("ex_rd", 64'(ex_rd), 64'(e.rd));
            check("ex_op1", ex_op1, e.op1);
            check("ex_op2", ex_op2, e.op2);
            check("ex_imm", ex_imm, e.imm);
        end
        check("stall_cnt", 64'(stall_cnt), 64'(e.n_stall));
        check("flush_cnt", 64'(flush_cnt), 64'(e.n_flush));
        small_s = (e.n_stall > SMALL_MAX) ? SMALL_MAX : e.n_stall;
        small_f = (e.n_flush > SMALL_MAX) ? SMALL_MAX : e.n_flush;
        check("sat_stall_cnt", 64'(s_stall_cnt), 64'(small_s));
        check("sat_flush_cnt", 64'(s_flush_cnt), 64'(small_f));
        m_valid = e.valid;
        m_rd    = e.rd;
        m_ctrl  = e.ctrl;
    endtask

    // Inputs are already set; check stall_out, predict the edge, clock, compare.
    task automatic apply_stimulus();
        exp_t e;
        logic hz, exp_stall;
        #1;
        hz = id_valid && m_valid && m_ctrl[CTRL_MEM_READ] && (m_rd != 5'd0)
             && ((m_rd == id_rs1) || (m_rd == id_rs2));
        exp_stall = hz && !flush && reset;
        check("stall_out", 64'(stall_out), 64'(exp_stall));
        check("sat_stall_out", 64'(s_stall_out), 64'(exp_stall));

        e.valid = 1'b0; e.ctrl = '0; e.data_known = 1'b1;
        e.pc = '0; e.op1 = '0; e.op2 = '0; e.imm = '0;
        e.rs1 = '0; e.rs2 = '0; e.rd = '0;
        if (!reset) begin
            n_stall = 0;
            n_flush = 0;
        end else begin
            e.pc  = id_pc;  e.imm = id_imm;
            e.rs1 = id_rs1; e.rs2 = id_rs2; e.rd = id_rd;
            e.op1 = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs1) ? wb_data : id_rdata1;
            e.op2 = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs2) ? wb_data : id_rdata2;
            if (flush || hz) begin
                e.data_known = 1'b0;
            end else begin
                e.valid = id_valid;
                e.ctrl  = id_valid ? id_ctrl : 9'd0;
            end
            if (exp_stall) n_stall++;
            if (flush && id_valid) n_flush++;
        end
        e.n_stall = n_stall;
        e.n_flush = n_flush;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_output();
    endtask

    initial begin
        checks = 0; failures = 0;
        m_valid = 0; m_rd = 0; m_ctrl = 0;
        n_stall = 0; n_flush = 0;

        // Reset with a would-be hazard pattern on the inputs.
        reset = 0; flush = 0;
        set_wb(1, 5'd3, 64'hDEAD);
        set_instr(1, 5'd3, 5'd4, 5'd5, 64'd11, 64'd22, CTRL_LD);
        apply_stimulus();
        apply_stimulus();

        $display("[TB] normal capture and bypass");
        reset = 1;
        set_wb(0, 5'd0, 64'd0);
        set_instr(0, 5'd1, 5'd2, 5'd3, 64'd1, 64'd2, CTRL_ALU);
        apply_stimulus();
        set_wb(1, 5'd5, 64'h1234);
        set_instr(1, 5'd5, 5'd6, 5'd8, 64'd72, 64'd99, CTRL_ALU);
        apply_stimulus();
        set_wb(1, 5'd0, 64'hFFFF);
        set_instr(1, 5'd0, 5'd0, 5'd9, 64'd0, 64'd0, CTRL_ALU);
        apply_stimulus();
        set_wb(1, 5'd12, 64'hABCD_0000_5555);
        set_instr(1, 5'd11, 5'd12, 5'd13, 64'd7, 64'd8, CTRL_SD);
        apply_stimulus();
        set_wb(0, 5'd11, 64'h9999);
        set_instr(1, 5'd11, 5'd11, 5'd14, 64'd17, 64'd18, CTRL_ALU);
        apply_stimulus();

        $display("[TB] load-use stall");
        set_wb(0, 5'd0, 64'd0);
        set_instr(1, 5'd1, 5'd2, 5'd7, 64'd100, 64'd200, CTRL_LD);
        apply_stimulus();
        set_instr(1, 5'd3, 5'd7, 5'd9, 64'd300, 64'd400, CTRL_ALU);
        apply_stimulus();
        apply_stimulus();
        set_instr(1, 5'd7, 5'd7, 5'd10, 64'd1, 64'd2, CTRL_ALU);
        apply_stimulus();

        $display("[TB] flush with hazard");
        set_instr(1, 5'd1, 5'd2, 5'd7, 64'd5, 64'd6, CTRL_LD);
        apply_stimulus();
        flush = 1;
        set_instr(1, 5'd3, 5'd7, 5'd9, 64'd7, 64'd8, CTRL_ALU);
        apply_stimulus();
        set_instr(0, 5'd3, 5'd4, 5'd9, 64'd7, 64'd8, CTRL_ALU);
        apply_stimulus();
        flush = 0;

        $display("[TB] invalid slot and no hazard on invalid consumer");
        set_instr(1, 5'd1, 5'd2, 5'd7, 64'd5, 64'd6, CTRL_LD);
        apply_stimulus();
        set_instr(0, 5'd7, 5'd7, 5'd7, 64'd5, 64'd6, CTRL_LD);
        apply_stimulus();

        $display("[TB] reset during stall");
        set_instr(1, 5'd1, 5'd2, 5'd7, 64'd5, 64'd6, CTRL_LD);
        apply_stimulus();
        set_instr(1, 5'd7, 5'd2, 5'd9, 64'd5, 64'd6, CTRL_ALU);
        reset = 0;
        apply_stimulus();
        reset = 1;
        apply_stimulus();

        $display("[TB] counter saturation");
        for (int i = 0; i < 20; i++) begin
            set_instr(1, 5'd7, 5'd2, 5'd7, 64'($urandom), 64'($urandom), CTRL_LD);
            apply_stimulus();
            apply_stimulus();
        end
        flush = 1;
        for (int i = 0; i < 17; i++) begin
            set_instr(1, 5'($urandom_range(1, 31)), 5'd2, 5'd3, 64'($urandom), 64'd0, CTRL_ALU);
            apply_stimulus();
        end
        flush = 0;
        set_instr(0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 9'd0);
        apply_stimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
